icapture: RTL and testbench
===========================

ICAPTURE -- requirements
Module: icapture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data path and register width.
REQ-002 The block SHALL have parameter REG_CTRL, default 3'd0, giving the control register address.
REQ-003 The block SHALL have parameter REG_PSCR, default 3'd1, giving the prescaler register address.
REQ-004 The block SHALL have parameter REG_CNTR, default 3'd2, giving the timebase counter address.
REQ-005 The block SHALL have parameter REG_CAP, default 3'd3, giving the capture register address (read-only).
REQ-006 The block SHALL have parameter REG_STAT, default 3'd4, giving the status register address.
REQ-007 The block SHALL have port io_clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port din, input, WIDTH bits: write data.
REQ-010 The block SHALL have port cs, input, 1 bit: chip select.
REQ-011 The block SHALL have port addr, input, 3 bits: register address.
REQ-012 The block SHALL have port wen, input, 1 bit: write enable; cs&~wen is a read.
REQ-013 The block SHALL have port pin, input, 1 bit: asynchronous external event input.
REQ-014 The block SHALL have port dout, output, WIDTH bits: registered read data.
REQ-015 The block SHALL have port irq, output, 1 bit: interrupt request.

Function
REQ-016 CTRL SHALL decode as: [0] EN, [1] IE, [3:2] EDGE (00 rising, 01 falling, 10 both, 11 none); other bits SHALL be stored and read back.
REQ-017 pin SHALL pass through a 2-flop synchronizer (s1, s2) plus history flop s3, clocked continuously regardless of EN.
REQ-018 Edge detect: rise = s2&~s3, fall = ~s2&s3; a pin change first sampled by s1 at edge E1 SHALL be captured at edge E3.
REQ-019 Prescaler: an 8-bit pre_cnt SHALL count io_clk while EN=1; when pre_cnt==PSCR[7:0] it SHALL reload 0 and assert tick for one cycle; EN=0 SHALL hold pre_cnt at 0 and tick low.
REQ-020 Tick period SHALL be PSCR[7:0]+1 io_clk cycles; PSCR=0 SHALL tick every cycle.
REQ-021 CNTR SHALL increment by 1 on tick, wrapping from all-ones to 0 without flag.
REQ-022 A CNTR write SHALL load din and take priority over a same-cycle tick.
REQ-023 On a selected edge with EN=1, CAP SHALL load the CNTR value present before that clock edge, and status flag CF SHALL set.
REQ-024 If CF is already 1 at a capture, OVR SHALL set and CAP SHALL be overwritten with the new value.
REQ-025 EN=0 or EDGE=11 SHALL suppress captures; CNTR SHALL hold while EN=0.
REQ-026 STAT read SHALL return {zeros, OVR, CF, EN} in bits [2:0].
REQ-027 STAT write SHALL clear CF when din[1]=1 and OVR when din[2]=1; a same-cycle capture SHALL win (flag set).
REQ-028 Writes to REG_CAP, and reads or writes to unmapped addresses, SHALL have no register effect; unmapped reads SHALL return 0.
REQ-029 Read: on cs&~wen, dout SHALL load the addressed register at that edge (1-cycle latency) and hold otherwise.
REQ-030 irq SHALL equal CF&IE combinationally from registered state.

Reset
REQ-031 reset SHALL asynchronously clear CTRL, PSCR, CNTR, CAP, CF, OVR, pre_cnt, tick, s1-s3 and dout to 0; irq SHALL be 0 while reset is asserted.
REQ-032 Reset mid-count or mid-capture SHALL discard the in-flight edge; no capture SHALL occur from the s3 transition after release.

Verification
REQ-033 PSCR=3, CTRL=1, CNTR=0: after 40 io_clk CNTR reads 10 (±1 per alignment), CF=0.
REQ-034 CTRL=3 (rising, IE), pin 0->1: CAP = CNTR value at E3, CF=1, irq=1 two cycles after sampling; STAT write 0x2 -> CF=0, irq=0.
REQ-035 Two rising edges without clearing CF: CAP holds second value, STAT reads 0x7; write 0x6 -> STAT reads 0x1.
REQ-036 EDGE=10, pin pulse 0->1->0 separated by 8 cycles: two captures differing by pulse width in ticks; EDGE=11: no capture.
REQ-037 CNTR write 0xFFFFFFFF, PSCR=0, EN=1: next read shows 0 then 1; write coinciding with tick loads din exactly.
REQ-038 Assert reset while CF=1 and pin toggling: all reads return 0, irq=0, no capture in the first 3 cycles after release.

Source files
------------

// File: rtl/icapture.sv
// Input-capture timer: prescaled timebase counter, synchronized external event input,
// edge-selected capture into CAP with CF/OVR status flags and a small register file.
module icapture #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] REG_CTRL = 3'd0,
    parameter logic [2:0] REG_PSCR = 3'd1,
    parameter logic [2:0] REG_CNTR = 3'd2,
    parameter logic [2:0] REG_CAP  = 3'd3,
    parameter logic [2:0] REG_STAT = 3'd4
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             cs,
    input  logic [2:0]       addr,
    input  logic             wen,
    input  logic             pin,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    logic [WIDTH-1:0] r_ctrl;
    logic [WIDTH-1:0] r_pscr;
    logic [WIDTH-1:0] r_cntr;
    logic [WIDTH-1:0] r_cap;
    logic             r_cf;
    logic             r_ovr;
    logic [7:0]       r_pre_cnt;
    logic             r_tick;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;

    logic             w_wr;
    logic             w_rd;
    logic             w_en;
    logic             w_ie;
    logic [1:0]       w_edge;
    logic             w_rise;
    logic             w_fall;
    logic             w_cap;
    logic             w_stat_wr;
    logic [WIDTH-1:0] w_rdata;

    assign w_wr      = cs & wen;
    assign w_rd      = cs & ~wen;
    assign w_en      = r_ctrl[0];
    assign w_ie      = r_ctrl[1];
    assign w_edge    = r_ctrl[3:2];
    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_stat_wr = w_wr && (addr == REG_STAT);

    // EDGE=11 matches no case and therefore never captures
    assign w_cap = w_en && (((w_edge == 2'b00) && w_rise) ||
                            ((w_edge == 2'b01) && w_fall) ||
                            ((w_edge == 2'b10) && (w_rise || w_fall)));

    assign irq = r_cf & w_ie;

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= 8'd0;
            r_tick    <= 1'b0;
        end else if (!w_en) begin
            r_pre_cnt <= 8'd0;
            r_tick    <= 1'b0;
        end else if (r_pre_cnt == r_pscr[7:0]) begin
            r_pre_cnt <= 8'd0;
            r_tick    <= 1'b1;
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
            r_tick    <= 1'b0;
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
            r_pscr <= '0;
            r_cntr <= '0;
        end else begin
            if (w_wr && (addr == REG_CTRL)) r_ctrl <= din;
            if (w_wr && (addr == REG_PSCR)) r_pscr <= din;
            // a host write wins over a coincident tick
            if (w_wr && (addr == REG_CNTR))
                r_cntr <= din;
            else if (r_tick && w_en)
                r_cntr <= r_cntr + WIDTH'(1);
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_cap <= '0;
            r_cf  <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            if (w_cap) r_cap <= r_cntr;
            if (w_cap)
                r_cf <= 1'b1;
            else if (w_stat_wr && din[1])
                r_cf <= 1'b0;
            if (w_cap && r_cf)
                r_ovr <= 1'b1;
            else if (w_stat_wr && din[2])
                r_ovr <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (addr)
            REG_CTRL: w_rdata = r_ctrl;
            REG_PSCR: w_rdata = r_pscr;
            REG_CNTR: w_rdata = r_cntr;
            REG_CAP:  w_rdata = r_cap;
            REG_STAT: w_rdata = {{(WIDTH-3){1'b0}}, r_ovr, r_cf, w_en};
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset)
            dout <= '0;
        else if (w_rd)
            dout <= w_rdata;
    end

endmodule

// File: tb/tb_icapture.sv
// Directed bench for icapture: register access, prescaler timing, edge capture,
// CF/OVR handling and reset behaviour, all checked against hand-computed values.
module tb_icapture;

    logic        io_clk;
    logic        reset;
    logic [31:0] din;
    logic        cs;
    logic [2:0]  addr;
    logic        wen;
    logic        pin;
    logic [31:0] dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_PSCR = 3'd1;
    localparam logic [2:0] A_CNTR = 3'd2;
    localparam logic [2:0] A_CAP  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    icapture #(.WIDTH(32)) dut (
        .io_clk (io_clk),
        .reset  (reset),
        .din    (din),
        .cs     (cs),
        .addr   (addr),
        .wen    (wen),
        .pin    (pin),
        .dout   (dout),
        .irq    (irq)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    // all drive/sample happens on the falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        @(negedge io_clk);
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; wen = 1'b0; addr = a;
        @(negedge io_clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; pin = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
        repeat (2) @(negedge io_clk);
        chk("reset_dout", dout, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        rd(A_CTRL, v); chk("rst_ctrl", v, 32'h0);
        rd(A_STAT, v); chk("rst_stat", v, 32'h0);
        rd(A_CNTR, v); chk("rst_cntr", v, 32'h0);

        wr(A_CTRL, 32'hA5A5_A5A0);
        rd(A_CTRL, v); chk("ctrl_rb", v, 32'hA5A5_A5A0);
        wr(A_PSCR, 32'h1234_5603);
        rd(A_PSCR, v); chk("pscr_rb", v, 32'h1234_5603);
        repeat (2) @(negedge io_clk);
        chk("dout_hold", dout, 32'h1234_5603);

        wr(A_CAP, 32'hDEAD_BEEF);
        rd(A_CAP, v); chk("cap_ro", v, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, v); chk("unmapped5", v, 32'h0);
        rd(3'd7, v); chk("unmapped7", v, 32'h0);

        wr(A_CNTR, 32'd7);
        repeat (10) @(negedge io_clk);
        rd(A_CNTR, v); chk("cntr_hold_en0", v, 32'd7);

        // PSCR=3: tick every 4 cycles
        wr(A_CNTR, 32'd0);
        wr(A_CTRL, 32'd1);
        repeat (40) @(negedge io_clk);
        rd(A_CNTR, v);
        checks++;
        assert (v >= 32'd9 && v <= 32'd11) else begin
            failures++;
            $error("FAIL pscr3_cntr: observed=%0d expected=9..11", v);
        end
        rd(A_STAT, v); chk("pscr3_stat", v, 32'h1);

        // PSCR=0, restart prescaler from 0 via EN toggle
        wr(A_CTRL, 32'd0);
        wr(A_PSCR, 32'd0);
        wr(A_CTRL, 32'd1);
        wr(A_CNTR, 32'h1234_5678);
        rd(A_CNTR, v); chk("cntr_load", v, 32'h1234_5678);
        wr(A_CNTR, 32'hFFFF_FFFF);
        @(negedge io_clk);
        rd(A_CNTR, v); chk("cntr_wrap0", v, 32'h0);
        rd(A_CNTR, v); chk("cntr_wrap1", v, 32'h1);

        // rising capture with IE
        wr(A_CTRL, 32'd3);
        wr(A_CNTR, 32'd100);
        pin = 1'b1;
        @(negedge io_clk); chk("irq_e1", {31'b0, irq}, 32'h0);
        @(negedge io_clk); chk("irq_e2", {31'b0, irq}, 32'h0);
        @(negedge io_clk); chk("irq_e3", {31'b0, irq}, 32'h1);
        rd(A_CAP, v);  chk("cap_rise", v, 32'd102);
        rd(A_STAT, v); chk("stat_cf", v, 32'h3);
        wr(A_STAT, 32'h2);
        chk("irq_clr", {31'b0, irq}, 32'h0);
        rd(A_STAT, v); chk("stat_cf_clr", v, 32'h1);

        // two rising edges -> overrun
        pin = 1'b0;
        repeat (4) @(negedge io_clk);
        rd(A_STAT, v); chk("fall_ignored", v, 32'h1);
        pin = 1'b1;
        repeat (4) @(negedge io_clk);
        pin = 1'b0;
        repeat (4) @(negedge io_clk);
        wr(A_CNTR, 32'd500);
        pin = 1'b1;
        repeat (4) @(negedge io_clk);
        rd(A_CAP, v);  chk("cap_second", v, 32'd502);
        rd(A_STAT, v); chk("stat_ovr", v, 32'h7);
        wr(A_STAT, 32'h6);
        rd(A_STAT, v); chk("stat_clr_all", v, 32'h1);
        chk("irq_after_clr", {31'b0, irq}, 32'h0);

        // EDGE=11: no capture
        wr(A_CTRL, 32'hD);
        pin = 1'b0;
        repeat (4) @(negedge io_clk);
        pin = 1'b1;
        repeat (4) @(negedge io_clk);
        pin = 1'b0;
        repeat (4) @(negedge io_clk);
        rd(A_STAT, v); chk("edge11_stat", v, 32'h1);
        rd(A_CAP, v);  chk("edge11_cap", v, 32'd502);

        // EDGE=10: both edges, 8-cycle pulse
        wr(A_CTRL, 32'h9);
        wr(A_CNTR, 32'd1000);
        pin = 1'b1;
        repeat (3) @(negedge io_clk);
        rd(A_CAP, v); chk("both_rise", v, 32'd1002);
        repeat (4) @(negedge io_clk);
        pin = 1'b0;
        repeat (4) @(negedge io_clk);
        rd(A_CAP, v);  chk("both_fall", v, 32'd1010);
        rd(A_STAT, v); chk("both_stat", v, 32'h7);
        chk("both_irq_ie0", {31'b0, irq}, 32'h0);

        // reset while CF=1 and pin toggling
        wr(A_STAT, 32'h6);
        wr(A_CTRL, 32'd3);
        pin = 1'b1;
        repeat (4) @(negedge io_clk);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        rd(A_CAP, v);
        reset = 1'b1;
        #1;
        chk("async_dout", dout, 32'h0);
        chk("async_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge io_clk);
            pin = ~pin;
        end
        chk("rst_hold_irq", {31'b0, irq}, 32'h0);
        pin = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge io_clk);
        chk("post_rst_irq", {31'b0, irq}, 32'h0);
        rd(A_STAT, v); chk("post_rst_stat", v, 32'h0);
        rd(A_CAP, v);  chk("post_rst_cap", v, 32'h0);
        rd(A_CTRL, v); chk("post_rst_ctrl", v, 32'h0);
        rd(A_PSCR, v); chk("post_rst_pscr", v, 32'h0);
        rd(A_CNTR, v); chk("post_rst_cntr", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
